beam_centroid_calc: RTL

BEAM_CENTROID_CALC -- requirements
Module: beam_centroid_calc

---
 rtl/beam_pkg.sv | 27 ++
 rtl/beam_centroid_mac.sv | 46 ++++
 rtl/beam_centroid_calc.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/beam_pkg.sv
// beam_pkg: shared constants, STATUS layout and FSM encoding for the beam centroid calculator.
package beam_pkg;

    localparam int WORDS_IN_DEF  = 163;
    localparam int HDR_WORDS_DEF = 3;
    localparam int OUT_WORDS     = 7;

    localparam int ST_SHORT_BIT = 16;
    localparam int ST_LONG_BIT  = 17;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RECEIVE = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;

    function automatic logic [31:0] pack_status(input logic [15:0] count,
                                                input logic        short_f,
                                                input logic        long_f);
        logic [31:0] st;
        st              = {16'd0, count};
        st[ST_SHORT_BIT] = short_f;
        st[ST_LONG_BIT]  = long_f;
        return st;
    endfunction

endpackage

// File: rtl/beam_centroid_mac.sv
// beam_centroid_mac: SUM / WSUM accumulator for two 16-bit samples per beat.
// One register stage holds the beat's partial sums before they are folded into the totals.
module beam_centroid_mac (
    input  logic        clk_clk,
    input  logic        rst_reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] beat,
    input  logic [8:0]  base_idx,
    output logic [31:0] sum,
    output logic [47:0] wsum
);

    logic [8:0]  idx_lo;
    logic [24:0] prod_hi;
    logic [24:0] prod_lo;
    logic        stg_vld;
    logic [16:0] stg_sum;
    logic [25:0] stg_wsum;

    // base_idx is always even (at most 318), so the odd channel never wraps
    assign idx_lo  = base_idx + 9'd1;
    assign prod_hi = {9'd0, beat[31:16]} * {16'd0, base_idx};
    assign prod_lo = {9'd0, beat[15:0]}  * {16'd0, idx_lo};

    always_ff @(posedge clk_clk) begin
        if (rst_reset || clear) begin
            stg_vld  <= 1'b0;
            stg_sum  <= '0;
            stg_wsum <= '0;
            sum      <= '0;
            wsum     <= '0;
        end else begin
            stg_vld <= enable;
            if (enable) begin
                stg_sum  <= {1'b0, beat[31:16]} + {1'b0, beat[15:0]};
                stg_wsum <= {1'b0, prod_hi} + {1'b0, prod_lo};
            end
            if (stg_vld) begin
                sum  <= sum + {15'd0, stg_sum};
                wsum <= wsum + {22'd0, stg_wsum};
            end
        end
    end

endmodule

// File: rtl/beam_centroid_calc.sv
// beam_centroid_calc: per-frame intensity sum and channel-weighted sum, emitted as a 7-word packet.
// Optional build macro BEAM_CENTROID_BASELINE_EN subtracts BASELINE (floored at 0) from each sample.
//
//   state   | meaning
//   IDLE    | waiting for SOP; non-SOP beats are dropped
//   RECEIVE | storing header, accumulating data beats
//   DRAIN   | frame exceeded WORDS_IN; beats accepted and dropped until EOP
//   FLUSH   | one cycle for the accumulator stage to retire the last beat
//   SEND    | presenting the 7 output words
module beam_centroid_calc
    import beam_pkg::*;
#(
    parameter int          WORDS_IN  = WORDS_IN_DEF,
    parameter int          HDR_WORDS = HDR_WORDS_DEF,
    parameter logic [15:0] BASELINE  = 16'd0
) (
    input  logic        clk_clk,
    input  logic        rst_reset,
    input  logic [31:0] data_in_data,
    input  logic        data_in_valid,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    input  logic [1:0]  data_in_empty,
    output logic        data_in_ready,
    output logic [31:0] data_out_data,
    output logic        data_out_valid,
    output logic        data_out_startofpacket,
    output logic        data_out_endofpacket,
    output logic [1:0]  data_out_empty,
    input  logic        data_out_ready
);

    logic [2:0]  state;
    logic [15:0] count;
    logic [15:0] count_nxt;
    logic [15:0] data_idx;
    logic        short_f;
    logic        long_f;
    logic [31:0] hdr [0:2];
    logic [2:0]  out_idx;
    logic        in_rst;
    logic        acc_in;
    logic        start;
    logic        beat_rx;
    logic        mac_en;
    logic [31:0] mac_beat;
    logic [31:0] sum;
    logic [47:0] wsum;
    logic [31:0] out_word;
    logic        unused_bits;

    // in_rst keeps ready low for every cycle the reset is sampled high
    assign data_in_ready = !in_rst &&
                           (state == S_IDLE || state == S_RECEIVE || state == S_DRAIN);
    assign acc_in    = data_in_valid && data_in_ready;
    assign start     = acc_in && data_in_startofpacket && (state == S_IDLE || state == S_RECEIVE);
    assign beat_rx   = acc_in && !data_in_startofpacket && (state == S_RECEIVE);
    assign count_nxt = count + 16'd1;
    assign data_idx  = count - 16'(HDR_WORDS);
    assign mac_en    = beat_rx && (count >= 16'(HDR_WORDS)) && (count < 16'(WORDS_IN));

`ifdef BEAM_CENTROID_BASELINE_EN
    logic [15:0] s_hi;
    logic [15:0] s_lo;
    assign s_hi     = (data_in_data[31:16] > BASELINE) ? data_in_data[31:16] - BASELINE : 16'd0;
    assign s_lo     = (data_in_data[15:0]  > BASELINE) ? data_in_data[15:0]  - BASELINE : 16'd0;
    assign mac_beat = {s_hi, s_lo};
`else
    localparam logic [15:0] baseline_unused = BASELINE;
    assign mac_beat = data_in_data;
`endif

    assign unused_bits = ^{data_in_empty, data_idx[15:8]};

    beam_centroid_mac u_mac (
        .clk_clk   (clk_clk),
        .rst_reset (rst_reset),
        .clear     (start),
        .enable    (mac_en),
        .beat      (mac_beat),
        .base_idx  ({data_idx[7:0], 1'b0}),
        .sum       (sum),
        .wsum      (wsum)
    );

    always_ff @(posedge clk_clk) begin
        in_rst <= rst_reset;
        if (rst_reset) begin
            state   <= S_IDLE;
            count   <= '0;
            short_f <= 1'b0;
            long_f  <= 1'b0;
            out_idx <= '0;
            hdr     <= '{default: '0};
        end else begin
            case (state)
                S_IDLE, S_RECEIVE: begin
                    if (start) begin
                        hdr[0]  <= data_in_data;
                        count   <= 16'd1;
                        long_f  <= 1'b0;
                        short_f <= 1'b0;
                        if (data_in_endofpacket) begin
                            short_f <= (16'd1 < 16'(WORDS_IN));
                            state   <= S_FLUSH;
                        end else begin
                            state <= S_RECEIVE;
                        end
                    end else if (beat_rx) begin
                        if (count < 16'(HDR_WORDS) && count < 16'd3)
                            hdr[count[1:0]] <= data_in_data;
                        count <= count_nxt;
                        if (data_in_endofpacket) begin
                            short_f <= (count_nxt < 16'(WORDS_IN));
                            state   <= S_FLUSH;
                        end else if (count_nxt == 16'(WORDS_IN)) begin
                            long_f <= 1'b1;
                            state  <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (acc_in) begin
                        if (count != 16'hFFFF)
                            count <= count_nxt;
                        if (data_in_endofpacket)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    out_idx <= '0;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (data_out_ready) begin
                        if (out_idx == 3'(OUT_WORDS - 1)) begin
                            out_idx <= '0;
                            state   <= S_IDLE;
                        end else begin
                            out_idx <= out_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_word = 32'd0;
        case (out_idx)
            3'd0:    out_word = hdr[0];
            3'd1:    out_word = hdr[1];
            3'd2:    out_word = hdr[2];
            3'd3:    out_word = sum;
            3'd4:    out_word = {16'd0, wsum[47:32]};
            3'd5:    out_word = wsum[31:0];
            3'd6:    out_word = pack_status(count, short_f, long_f);
            default: out_word = 32'd0;
        endcase
    end

    assign data_out_valid         = (state == S_SEND);
    assign data_out_data          = data_out_valid ? out_word : 32'd0;
    assign data_out_startofpacket = data_out_valid && (out_idx == 3'd0);
    assign data_out_endofpacket   = data_out_valid && (out_idx == 3'(OUT_WORDS - 1));
    assign data_out_empty         = 2'b00;

endmodule
